// File: rtl/ctrl_ram_writer_pkg.sv
// Shared definitions for the control-beat RAM writer: header field layout, FSM states, beat width.
// No logic here; pure types and constants.
// Imported by the writer and anything that builds control packets for it.
package ctrl_ram_writer_pkg;

    localparam int CTRL_W = 64;

    localparam int MOD_HI = 63;
    localparam int MOD_LO = 56;
    localparam int RES_HI = 55;
    localparam int RES_LO = 48;
    localparam int IDX_HI = 47;
    localparam int IDX_LO = 32;
    localparam int CNT_HI = 31;
    localparam int CNT_LO = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DROP  = 2'd2
    } state_t;

endpackage

// File: rtl/ctrl_ram_writer.sv
// Filters addressed control packets and turns data beats into RAM port-A write strobes.
// Latency: a data beat accepted on edge k drives ram_ena/ram_wea for the cycle following edge k.
// Backpressure: none; s_ctrl_ready is held high from the first edge after reset release.
module ctrl_ram_writer
    import ctrl_ram_writer_pkg::*;
#(
    parameter int         ADDR_BITS   = 5,
    parameter int         DATA_BITS   = 32,
    parameter logic [7:0] MODULE_ID   = 8'h00,
    parameter logic [7:0] RESOURCE_ID = 8'h00
) (
    input  logic                 clk,
    input  logic                 aresetn,
    input  logic [CTRL_W-1:0]    s_ctrl_data,
    input  logic                 s_ctrl_valid,
    input  logic                 s_ctrl_last,
    output logic                 s_ctrl_ready,
    output logic                 ram_ena,
    output logic                 ram_wea,
    output logic [ADDR_BITS-1:0] ram_addra,
    output logic [DATA_BITS-1:0] ram_dina,
    output logic                 busy,
    output logic [15:0]          err_cnt
);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [ADDR_BITS-1:0]   r_addr;
    logic [ADDR_BITS-1:0]   w_addr_nxt;
    logic [15:0]            r_remaining;
    logic [15:0]            w_remaining_nxt;

    logic                   r_ready;
    logic                   r_wr;
    logic [ADDR_BITS-1:0]   r_addra;
    logic [DATA_BITS-1:0]   r_dina;
    logic [15:0]            r_err_cnt;

    logic                   w_accept;
    logic                   w_wr;
    logic                   w_err;
    logic [7:0]             w_hdr_mod;
    logic [7:0]             w_hdr_res;
    logic [15:0]            w_hdr_idx;
    logic [15:0]            w_hdr_cnt;
    logic                   w_id_match;
    logic                   w_idx_ok;
    logic                   w_cnt_zero;

    assign w_accept   = s_ctrl_valid && r_ready;
    assign w_hdr_mod  = s_ctrl_data[MOD_HI:MOD_LO];
    assign w_hdr_res  = s_ctrl_data[RES_HI:RES_LO];
    assign w_hdr_idx  = s_ctrl_data[IDX_HI:IDX_LO];
    assign w_hdr_cnt  = s_ctrl_data[CNT_HI:CNT_LO];
    assign w_id_match = (w_hdr_mod == MODULE_ID) && (w_hdr_res == RESOURCE_ID);
    assign w_idx_ok   = (w_hdr_idx >> ADDR_BITS) == 16'd0;
    assign w_cnt_zero = (w_hdr_cnt == 16'd0);

    always_comb begin
        w_state_nxt     = r_state;
        w_addr_nxt      = r_addr;
        w_remaining_nxt = r_remaining;
        w_wr            = 1'b0;
        w_err           = 1'b0;
        if (w_accept) begin
            case (r_state)
                IDLE: begin
                    if (w_id_match) begin
                        if (w_idx_ok && !w_cnt_zero && !s_ctrl_last) begin
                            w_state_nxt     = WRITE;
                            w_addr_nxt      = w_hdr_idx[ADDR_BITS-1:0];
                            w_remaining_nxt = w_hdr_cnt;
                        end else if (!(w_cnt_zero && s_ctrl_last)) begin
                            // Malformed header: counted once, rest of packet swallowed.
                            w_err = 1'b1;
                            if (!s_ctrl_last) begin
                                w_state_nxt = DROP;
                            end
                        end
                    end else if (!s_ctrl_last) begin
                        w_state_nxt = DROP;
                    end
                end
                WRITE: begin
                    w_wr            = 1'b1;
                    w_addr_nxt      = r_addr + ADDR_BITS'(1);
                    w_remaining_nxt = r_remaining - 16'd1;
                    if (r_remaining == 16'd1) begin
                        if (s_ctrl_last) begin
                            w_state_nxt = IDLE;
                        end else begin
                            w_err       = 1'b1;
                            w_state_nxt = DROP;
                        end
                    end else if (s_ctrl_last) begin
                        w_err       = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
                DROP: begin
                    if (s_ctrl_last) begin
                        w_state_nxt = IDLE;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_remaining <= 16'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_addr      <= w_addr_nxt;
            r_remaining <= w_remaining_nxt;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_ready   <= 1'b0;
            r_wr      <= 1'b0;
            r_addra   <= '0;
            r_dina    <= '0;
            r_err_cnt <= 16'd0;
        end else begin
            r_ready <= 1'b1;
            r_wr    <= w_wr;
            if (w_wr) begin
                r_addra <= r_addr;
                r_dina  <= s_ctrl_data[DATA_BITS-1:0];
            end
            if (w_err && (r_err_cnt != 16'hFFFF)) begin
                r_err_cnt <= r_err_cnt + 16'd1;
            end
        end
    end

    assign s_ctrl_ready = r_ready;
    assign ram_ena      = r_wr;
    assign ram_wea      = r_wr;
    assign ram_addra    = r_addra;
    assign ram_dina     = r_dina;
    assign busy         = (r_state != IDLE);
    assign err_cnt      = r_err_cnt;

endmodule
